// File: rtl/adc_acq_pkg.sv
// Shared types and constants for the ADC acquisition sequencer.
// The optional over-range detector is enabled by defining ADC_OVERRANGE_EN.
package adc_acq_pkg;

    localparam int ADC_MV_W   = 16;
    localparam int DEF_OVR_MV = 4900;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2,
        OUTPUT = 2'd3
    } adc_acq_state_e;

    // Requested averaging exponents above the supported maximum fall back to the maximum.
    function automatic logic [2:0] clamp_avg_log2(input logic [2:0] n, input logic [2:0] max_n);
        return (n > max_n) ? max_n : n;
    endfunction

endpackage

// File: rtl/adc_acq_ctrl_accum.sv
// Dual-channel signed accumulator with clear/enable and a shifted (averaged) view
// of the running sum including the sample currently presented.
// With ADC_OVERRANGE_EN defined it also tracks a sticky |mV| over-range flag.
module adc_dual_accum
    import adc_acq_pkg::*;
#(
    parameter int MAX_AVG_LOG2 = 4,
    parameter int OVR_MV       = DEF_OVR_MV
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       en,
    input  logic [2:0]                 shift,
    input  logic signed [ADC_MV_W-1:0] ch1_in,
    input  logic signed [ADC_MV_W-1:0] ch2_in,
`ifdef ADC_OVERRANGE_EN
    output logic                       ovr_nxt,
`endif
    output logic signed [ADC_MV_W-1:0] res_ch1,
    output logic signed [ADC_MV_W-1:0] res_ch2
);

    // Wide enough for 2^MAX_AVG_LOG2 full-scale samples, so no overflow is possible.
    localparam int ACC_W = ADC_MV_W + MAX_AVG_LOG2;

    logic signed [ACC_W-1:0] acc1;
    logic signed [ACC_W-1:0] acc2;
    logic signed [ACC_W-1:0] sum1;
    logic signed [ACC_W-1:0] sum2;

    // Sum including the current sample; this is what the last ACCUM cycle hands out.
    always_comb begin
        sum1    = acc1 + {{MAX_AVG_LOG2{ch1_in[ADC_MV_W-1]}}, ch1_in};
        sum2    = acc2 + {{MAX_AVG_LOG2{ch2_in[ADC_MV_W-1]}}, ch2_in};
        res_ch1 = ADC_MV_W'(sum1 >>> shift);
        res_ch2 = ADC_MV_W'(sum2 >>> shift);
    end

    // Accumulator registers: cleared at window start, summing while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc1 <= '0;
            acc2 <= '0;
        end else if (clr) begin
            acc1 <= '0;
            acc2 <= '0;
        end else if (en) begin
            acc1 <= sum1;
            acc2 <= sum2;
        end
    end

`ifdef ADC_OVERRANGE_EN
    localparam logic signed [ADC_MV_W-1:0] OVR_LIM = ADC_MV_W'(OVR_MV);

    logic ovr_q;
    logic ovr_hit;

    assign ovr_hit = en && ((ch1_in > OVR_LIM) || (ch1_in < -OVR_LIM) ||
                            (ch2_in > OVR_LIM) || (ch2_in < -OVR_LIM));
    assign ovr_nxt = ovr_q | ovr_hit;

    // Sticky over-range flag for the current window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else if (clr) begin
            ovr_q <= 1'b0;
        end else if (en) begin
            ovr_q <= ovr_nxt;
        end
    end
`endif

endmodule

// File: rtl/adc_acq_ctrl.sv
// Acquisition sequencer: trigger -> settle delay -> average 2^N samples per
// channel -> present the averaged pair downstream.
// Optional over-range flag enabled by defining ADC_OVERRANGE_EN.
//
// Output handshake: avg_valid/avg_ch*/ovr are held stable from the cycle
// avg_valid rises until a cycle with avg_valid && avg_ready; avg_ready is
// ignored while avg_valid is low. A trigger coinciding with that accepting
// cycle starts the next window immediately.
module adc_acq_ctrl
    import adc_acq_pkg::*;
#(
    parameter int MAX_AVG_LOG2 = 4,
    parameter int SETTLE_W     = 16,
    parameter int OVR_MV       = DEF_OVR_MV
) (
    input  logic                       ad_clk,
    input  logic                       rst_n,
    input  logic                       trig,
    input  logic [SETTLE_W-1:0]        cfg_settle,
    input  logic [2:0]                 cfg_avg_log2,
    input  logic signed [ADC_MV_W-1:0] volt_ch1,
    input  logic signed [ADC_MV_W-1:0] volt_ch2,
    output logic signed [ADC_MV_W-1:0] avg_ch1,
    output logic signed [ADC_MV_W-1:0] avg_ch2,
    output logic                       avg_valid,
    input  logic                       avg_ready,
    output logic                       busy,
    output logic                       trig_dropped,
    output logic                       ovr,
    output adc_acq_state_e             dbg_state
);

    localparam int CNT_W = MAX_AVG_LOG2 + 1;

    adc_acq_state_e state;
    adc_acq_state_e state_nxt;

    logic [SETTLE_W-1:0]        settle_cnt;
    logic [CNT_W-1:0]           smp_cnt;
    logic [CNT_W-1:0]           smp_last;
    logic [2:0]                 n_lat;
    logic [2:0]                 n_cfg;
    logic                       handshake;
    logic                       trig_accept;
    logic                       last_smp;
    logic signed [ADC_MV_W-1:0] res_ch1;
    logic signed [ADC_MV_W-1:0] res_ch2;

    assign handshake   = (state == OUTPUT) && avg_ready;
    assign trig_accept = trig && ((state == IDLE) || handshake);
    assign n_cfg       = clamp_avg_log2(cfg_avg_log2, 3'(MAX_AVG_LOG2));
    assign smp_last    = CNT_W'((32'd1 << n_lat) - 32'd1);
    assign last_smp    = (state == ACCUM) && (smp_cnt == smp_last);

    assign avg_valid = (state == OUTPUT);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a zero settle time skips SETTLE entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (trig_accept) begin
                    state_nxt = (cfg_settle == '0) ? ACCUM : SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (smp_cnt == smp_last) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                if (handshake) begin
                    if (trig_accept) begin
                        state_nxt = (cfg_settle == '0) ? ACCUM : SETTLE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Config latches and window counters; config is only sampled on trigger acceptance.
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            smp_cnt    <= '0;
            n_lat      <= '0;
        end else if (trig_accept) begin
            settle_cnt <= (cfg_settle == '0) ? '0 : (cfg_settle - SETTLE_W'(1));
            smp_cnt    <= '0;
            n_lat      <= n_cfg;
        end else if ((state == SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
        end else if (state == ACCUM) begin
            smp_cnt <= smp_cnt + CNT_W'(1);
        end
    end

    // Result registers, captured on the last ACCUM cycle and held through OUTPUT.
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_ch1 <= '0;
            avg_ch2 <= '0;
        end else if (last_smp) begin
            avg_ch1 <= res_ch1;
            avg_ch2 <= res_ch2;
        end
    end

    // One-cycle flag for a trigger that arrived while a window was in progress.
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_dropped <= 1'b0;
        end else begin
            trig_dropped <= trig && !trig_accept && (state != IDLE);
        end
    end

`ifdef ADC_OVERRANGE_EN
    logic ovr_nxt;
    logic ovr_q;

    // Over-range result captured with the averages; only presented with avg_valid.
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else if (last_smp) begin
            ovr_q <= ovr_nxt;
        end
    end

    assign ovr = ovr_q && (state == OUTPUT);
`else
    assign ovr = 1'b0;
`endif

    adc_dual_accum #(
        .MAX_AVG_LOG2 (MAX_AVG_LOG2),
        .OVR_MV       (OVR_MV)
    ) u_accum (
        .clk     (ad_clk),
        .rst_n   (rst_n),
        .clr     (trig_accept),
        .en      (state == ACCUM),
        .shift   (n_lat),
        .ch1_in  (volt_ch1),
        .ch2_in  (volt_ch2),
`ifdef ADC_OVERRANGE_EN
        .ovr_nxt (ovr_nxt),
`endif
        .res_ch1 (res_ch1),
        .res_ch2 (res_ch2)
    );

endmodule
